// File: rtl/bus_trmnl_adptr_if.sv
// Bus-side port of one terminal: request/pop from the terminal's TX queue,
// push into the terminal's RX queue.
interface bus_trmnl_adptr_if #(
    parameter int pckg_sz = 16
);
    logic               pndng;
    logic               pop;
    logic [pckg_sz-1:0] D_pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;

    // master: the bus/arbiter side
    modport master (input pndng, D_pop, output pop, push, D_push);
    // slave: the terminal adapter
    modport slave  (output pndng, D_pop, input pop, push, D_push);
endinterface

// File: rtl/bus_trmnl_adptr.sv
// Terminal adapter: TX FIFO toward the bus, address-filtered RX FIFO from it.
// Both queues are first-word fall-through with registered flags.
module bus_trmnl_adptr_fifo #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8,
    localparam int AW     = $clog2(depth),
    localparam int CW     = AW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [pckg_sz-1:0] wdata,
    input  logic               rd,
    output logic [pckg_sz-1:0] rdata,
    output logic               valid,
    output logic               full,
    output logic [CW-1:0]      cnt,
    output logic               drop
);
    logic [pckg_sz-1:0] mem [depth];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      cnt_nxt;
    logic               rd_eff, wr_acc;

    // A read only counts when data is present; a full queue still accepts a
    // write when the same-cycle read frees the slot.
    assign rd_eff = rd && valid;
    assign wr_acc = wr && (!full || rd_eff);
    assign drop   = wr && full && !rd_eff;
    assign rdata  = mem[rd_ptr];

    always_comb begin
        cnt_nxt = cnt;
        case ({wr_acc, rd_eff})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_eff) rd_ptr <= rd_ptr + 1'b1;
            cnt   <= cnt_nxt;
            valid <= (cnt_nxt != '0);
            full  <= (cnt_nxt == CW'(depth));
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= wdata;
    end
endmodule

module bus_trmnl_adptr #(
    parameter int         pckg_sz   = 16,
    parameter int         depth     = 8,
    parameter logic [7:0] id        = 8'd0,
    parameter logic [7:0] broadcast = 8'hFF,
    localparam int        CW        = $clog2(depth) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic               tx_ovf,
    input  logic               rx_rd,
    output logic               rx_valid,
    output logic [pckg_sz-1:0] rx_data,
    output logic [CW-1:0]      rx_cnt,
    output logic [7:0]         rx_drop_cnt,
    bus_trmnl_adptr_if.slave   bus
);
    logic [CW-1:0] tx_cnt;
    logic          tx_drop, rx_drop, rx_match;
    logic [7:0]    dst;

    assign dst      = bus.D_push[pckg_sz-1:pckg_sz-8];
    assign rx_match = bus.push && (dst == id || dst == broadcast);

    bus_trmnl_adptr_fifo #(.pckg_sz(pckg_sz), .depth(depth)) u_tx (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_wr),
        .wdata (tx_data),
        .rd    (bus.pop),
        .rdata (bus.D_pop),
        .valid (bus.pndng),
        .full  (tx_full),
        .cnt   (tx_cnt),
        .drop  (tx_drop)
    );

    bus_trmnl_adptr_fifo #(.pckg_sz(pckg_sz), .depth(depth)) u_rx (
        .clk   (clk),
        .reset (reset),
        .wr    (rx_match),
        .wdata (bus.D_push),
        .rd    (rx_rd),
        .rdata (rx_data),
        .valid (rx_valid),
        .full  (),
        .cnt   (rx_cnt),
        .drop  (rx_drop)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ovf      <= 1'b0;
            rx_drop_cnt <= '0;
        end else begin
            tx_ovf <= tx_drop;
            if (rx_drop && rx_drop_cnt != 8'hFF) rx_drop_cnt <= rx_drop_cnt + 1'b1;
        end
    end

    // TX occupancy is tracked for the flags only; no port exposes it.
    logic unused_tx_cnt;
    assign unused_tx_cnt = ^tx_cnt;
endmodule
